// File: rtl/tc_to_signmag_serial_pkg.sv
// tc_to_signmag_serial_pkg: state encoding and width constants shared with the ALU datapath blocks
package tc_to_signmag_serial_pkg;
   localparam int WIDTH_DEF = 16;
   localparam int CNT_W = $clog2(WIDTH_DEF);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/tc_to_signmag_serial_if.sv
// tc_to_signmag_serial_if: word-in / result-out valid-ready bundle for the serial decoder
interface tc_to_signmag_serial_if
   import tc_to_signmag_serial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_cmp;
   logic             out_valid;
   logic             out_ready;
   logic             out_sign;
   logic [WIDTH-1:0] out_mag;
   logic             out_ovf;
   logic             busy;
   modport master (
      output in_valid, in_data, in_cmp, out_ready,
      input  in_ready, out_valid, out_sign, out_mag, out_ovf, busy
   );
   modport slave (
      input  in_valid, in_data, in_cmp, out_ready,
      output in_ready, out_valid, out_sign, out_mag, out_ovf, busy
   );
endinterface

// File: rtl/tc_serial_bit.sv
// tc_serial_bit: copy-until-first-1-then-invert cell for LSB-first two's-complement negation
module tc_serial_bit (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic neg,
   input  logic b,
   output logic o
);
   logic seen_one;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seen_one <= 1'b0;
      else seen_one <= clr ? 1'b0 : (en ? (seen_one | b) : seen_one);
   end
   assign o = (neg & seen_one) ? ~b : b;
endmodule

// File: rtl/tc_to_signmag_serial.sv
// tc_to_signmag_serial: bit-serial two's-complement to sign-magnitude decoder, LSB first, one word per transaction
module tc_to_signmag_serial
   import tc_to_signmag_serial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   tc_to_signmag_serial_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   state_t           state, state_nx;
   logic [WIDTH-1:0] shreg, mag_sr;
   logic [CW-1:0]    cnt;
   logic             sign_q, ovf_q, accept, shift, last, done, o;
   assign shift  = state == ST_SHIFT;
   assign done   = state == ST_DONE;
   assign last   = shift & (cnt == CW'(WIDTH - 1));
   assign accept = bus.in_valid & (state == ST_IDLE);
   always_comb begin
      state_nx = state;
      state_nx = accept ? ST_SHIFT :
                 last ? ST_DONE :
                 (done & bus.out_ready) ? ST_IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         shreg  <= '0;
         mag_sr <= '0;
         cnt    <= '0;
         sign_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            shreg  <= bus.in_data;
            mag_sr <= '0;
            cnt    <= '0;
            sign_q <= bus.in_cmp & bus.in_data[WIDTH-1];
            ovf_q  <= bus.in_cmp & (bus.in_data == MOST_NEG);
         end else if (shift) begin
            shreg  <= shreg >> 1;
            mag_sr <= {o, mag_sr[WIDTH-1:1]};
            cnt    <= cnt + CW'(1);
         end
      end
   end
   tc_serial_bit u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (accept),
      .en   (shift),
      .neg  (sign_q),
      .b    (shreg[0]),
      .o    (o)
   );
   // result fields are masked outside DONE so a partial magnitude is never visible
   assign bus.in_ready  = state == ST_IDLE;
   assign bus.out_valid = done;
   assign bus.out_sign  = done & sign_q;
   assign bus.out_ovf   = done & ovf_q;
   assign bus.out_mag   = done ? mag_sr : '0;
   assign bus.busy      = shift | done;
endmodule

// File: tb/tb_tc_to_signmag_serial.sv
// tb_tc_to_signmag_serial: randomized and directed checks of the serial sign-magnitude decoder
module tb_tc_to_signmag_serial;
   localparam int W = 16;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   tc_to_signmag_serial_if #(.WIDTH(W)) bus ();
   tc_to_signmag_serial #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   // reference: {sign, ovf, magnitude} from plain signed arithmetic
   function automatic logic [W+1:0] ref_dec(input logic [W-1:0] d, input logic c);
      int v;
      logic s, ov;
      logic [W-1:0] m;
      v  = int'($signed(d));
      s  = c && (v < 0);
      m  = s ? W'(-v) : d;
      ov = s && (-v > (2 ** (W - 1)) - 1);
      return {s, ov, m};
   endfunction
   task automatic send_word(input logic [W-1:0] d, input logic c, input string nm);
      int t = 0;
      bus.in_data  = d;
      bus.in_cmp   = c;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && t < 60) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!bus.in_ready) begin
         errors++;
         $display("FAIL %s accept_timeout in_ready=%b exp 1", nm, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic get_result(input logic [W-1:0] d, input logic c, input int stall, input string nm);
      int lat = 0;
      logic [W+1:0] e;
      e = ref_dec(d, c);
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== W) begin
         errors++;
         $display("FAIL %s latency got %0d exp %0d", nm, lat, W);
      end
      for (int i = 0; i < stall; i++) begin
         checks++;
         if (bus.out_mag !== e[W-1:0] || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s hold mag=%h rdy=%b vld=%b exp mag=%h rdy=0 vld=1", nm, bus.out_mag, bus.in_ready, bus.out_valid, e[W-1:0]);
         end
         @(negedge clk);
      end
      checks++;
      if (bus.out_sign !== e[W+1]) begin
         errors++;
         $display("FAIL %s sign d=%h c=%b got %b exp %b", nm, d, c, bus.out_sign, e[W+1]);
      end
      checks++;
      if (bus.out_mag !== e[W-1:0]) begin
         errors++;
         $display("FAIL %s mag d=%h c=%b got %h exp %h", nm, d, c, bus.out_mag, e[W-1:0]);
      end
      checks++;
      if (bus.out_ovf !== e[W] || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL %s ovf/busy d=%h got %b/%b exp %b/1", nm, d, bus.out_ovf, bus.busy, e[W]);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s release vld=%b rdy=%b exp 0/1", nm, bus.out_valid, bus.in_ready);
      end
   endtask
   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl rdy/vld/busy=%b%b%b exp 100", bus.in_ready, bus.out_valid, bus.busy);
      end
      checks++;
      if (bus.out_sign !== 1'b0 || bus.out_mag !== '0 || bus.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_data sign=%b mag=%h ovf=%b exp 0/0000/0", bus.out_sign, bus.out_mag, bus.out_ovf);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release rdy=%b vld=%b exp 1/0", bus.in_ready, bus.out_valid);
      end
   endtask
   task automatic test_directed;
      logic [W:0] vec [8] = '{{16'h0005, 1'b1}, {16'hFFFB, 1'b1}, {16'h8001, 1'b1}, {16'h8000, 1'b1},
                              {16'h0000, 1'b1}, {16'hFFFB, 1'b0}, {16'h0000, 1'b0}, {16'h7FFF, 1'b1}};
      for (int i = 0; i < 8; i++) begin
         send_word(vec[i][W:1], vec[i][0], "directed");
         get_result(vec[i][W:1], vec[i][0], 0, "directed");
      end
   endtask
   task automatic test_backpressure;
      int t = 0;
      send_word(16'hFFFB, 1'b1, "bp");
      while (!bus.out_valid && t < 40) begin
         @(negedge clk);
         t++;
      end
      bus.in_data  = 16'h1111;
      bus.in_cmp   = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_sign !== 1'b1 || bus.out_mag !== 16'h0005 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold vld=%b sign=%b mag=%h rdy=%b exp 1/1/0005/0", bus.out_valid, bus.out_sign, bus.out_mag, bus.in_ready);
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_handshake vld=%b rdy=%b busy=%b exp 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_pending_accept busy=%b exp 1", bus.busy);
      end
      get_result(16'h1111, 1'b1, 0, "bp_next");
   endtask
   task automatic test_reset_mid_shift;
      send_word(16'hFFFB, 1'b1, "rst_mid");
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.out_mag !== '0 || bus.out_sign !== 1'b0 || bus.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_outputs rdy=%b vld=%b busy=%b mag=%h sign=%b ovf=%b exp 1/0/0/0000/0/0",
                  bus.in_ready, bus.out_valid, bus.busy, bus.out_mag, bus.out_sign, bus.out_ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_word(16'h1234, 1'b1, "rst_after");
      get_result(16'h1234, 1'b1, 0, "rst_after");
      send_word(16'hFFFB, 1'b1, "rst_after_neg");
      get_result(16'hFFFB, 1'b1, 0, "rst_after_neg");
   endtask
   task automatic test_random;
      logic [W-1:0] d;
      logic c;
      for (int n = 0; n < 2500; n++) begin
         d = W'($urandom);
         c = $urandom_range(0, 3) != 0;
         case ($urandom_range(0, 15))
            0: d = 16'h8000;
            1: d = 16'h0000;
            2: d = 16'hFFFF;
            3: d = 16'h7FFF;
            default: ;
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send_word(d, c, "random");
         get_result(d, c, $urandom_range(0, 3), "random");
      end
   endtask
   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_cmp    = 1'b0;
      bus.out_ready = 1'b0;
      test_reset;
      test_directed;
      test_backpressure;
      test_reset_mid_shift;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
